// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// One WIDTH/STAGES-bit slice is rippled per register stage.
module pipelined_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int S = WIDTH / STAGES;

  logic adv;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q;
  logic              ovf_d;

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [S:0]       sl;
    logic [WIDTH-1:0] s_nx;

    if (k == 0) begin : g_head
      assign a_in = in0;
      assign b_in = sub ? ~in1 : in1;
      assign s_in = '0;
      assign c_in = sub | carry_in;
      assign v_in = in_valid & adv;
    end else begin : g_body
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
    end

    assign sl = {1'b0, a_in[k*S +: S]}
              + {1'b0, b_in[k*S +: S]}
              + {{S{1'b0}}, c_in};

    // merge this stage's slice into the de-skewed result word
    always_comb begin
      s_nx = s_in;
      s_nx[k*S +: S] = sl[S-1:0];
    end

    assign a_d[k] = a_in;
    assign b_d[k] = b_in;
    assign s_d[k] = s_nx;
    assign c_d[k] = sl[S];
    assign v_d[k] = v_in;

    if (k == STAGES - 1) begin : g_tail
      // a^b^sum at the MSB recovers the carry into the MSB
      assign ovf_d = a_in[WIDTH-1] ^ b_in[WIDTH-1]
                   ^ s_nx[WIDTH-1] ^ sl[S];
    end
  end

  // whole pipe shifts together on adv; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca: 32/4 main instance,
// plus 8/1 and 8/8 degenerate instances.
module tb_pipelined_rca;

  localparam int W   = 32;
  localparam int STG = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         sub;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry_out;
  logic         overflow;

  logic       d_v;
  logic [7:0] d_a;
  logic [7:0] d_b;
  logic       d_c;
  logic       r1_rdy, r1_v, r1_c, r1_ovf;
  logic [7:0] r1_o;
  logic       r8_rdy, r8_v, r8_c, r8_ovf;
  logic [7:0] r8_o;

  typedef struct {
    logic [33:0] exp;
    int          acc;
    int          st;
  } beat_t;

  beat_t       q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          irdy_lo = 0;
  int          last_ret = 0;
  logic [33:0] cur_exp = '0;
  logic        held_v = 1'b0;
  logic [W-1:0] held = '0;

  pipelined_rca #(.WIDTH(W), .STAGES(STG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .sub(sub), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry_out(carry_out), .overflow(overflow)
  );

  pipelined_rca #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d_v), .in_ready(r1_rdy),
    .in0(d_a), .in1(d_b), .sub(1'b0), .carry_in(d_c),
    .out_valid(r1_v), .out_ready(1'b1),
    .out(r1_o), .carry_out(r1_c), .overflow(r1_ovf)
  );

  pipelined_rca #(.WIDTH(8), .STAGES(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d_v), .in_ready(r8_rdy),
    .in0(d_a), .in1(d_b), .sub(1'b0), .carry_in(d_c),
    .out_valid(r8_v), .out_ready(1'b1),
    .out(r8_o), .carry_out(r8_c), .overflow(r8_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s,
                                        input logic c);
    logic [31:0] bb;
    logic        ci;
    logic [32:0] full;
    logic [31:0] low;
    bb   = s ? ~b : b;
    ci   = s | c;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
    low  = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + {31'd0, ci};
    return {low[31] ^ full[32], full[32], full[31:0]};
  endfunction

  // scoreboard: push on accept, pop and compare on retire
  always @(negedge clk) begin : mon
    beat_t e;
    if (rst) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (!in_ready) irdy_lo++;
      if (out_valid && !out_ready) begin
        if (held_v) check("hold", out, held);
        held   = out;
        held_v = 1'b1;
        stalls++;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("out", out, e.exp[31:0]);
          check("cout", carry_out, e.exp[32]);
          check("ovf", overflow, e.exp[33]);
          check("lat", cyc, e.acc + STG + stalls - e.st);
          last_ret = cyc;
        end
      end
      if (in_valid && in_ready)
        q.push_back('{cur_exp, cyc, stalls});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic s,
                      input logic c,
                      input logic [33:0] e);
    bit ok;
    ok       = 1'b0;
    in0      = a;
    in1      = b;
    sub      = s;
    carry_in = c;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_rnd;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    a = $urandom;
    b = $urandom;
    s = 1'($urandom_range(0, 1));
    c = 1'($urandom_range(0, 1));
    send(a, b, s, c, model(a, b, s, c));
  endtask

  task automatic drain;
    for (int i = 0; i < 60 && (q.size() != 0 || out_valid); i++)
      tick();
    check("drain", q.size(), 0);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int k;
    int l1;
    int l8;
    logic [8:0] v1;
    logic [8:0] v8;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in0       = '0;
    in1       = '0;
    sub       = 1'b0;
    carry_in  = 1'b0;
    d_v       = 1'b0;
    d_a       = '0;
    d_b       = '0;
    d_c       = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ovalid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_cout", carry_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_irdy", in_ready, 1);
    tick();

    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 34'h1_0000_0000);
    send(32'd5, 32'd7, 1'b1, 1'b0, 34'h0_FFFF_FFFE);
    send(32'd5, 32'd7, 1'b1, 1'b1, 34'h0_FFFF_FFFE);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 34'h2_8000_0000);
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 34'h3_7FFF_FFFF);
    drain();

    irdy_lo = 0;
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rnd();
      end
      begin
        k = 0;
        while (!out_valid && k < 20) begin
          tick();
          k++;
        end
        if (k == 20) check("stall_timeout", 0, 1);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("irdy_lo", irdy_lo, 3);
    check("last_ret", last_ret - t0, 14);

    repeat (3) send_rnd();
    rst      = 1'b1;
    in0      = $urandom;
    in1      = $urandom;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_ovalid", out_valid, 0);
    check("mid_out", out, 0);
    check("mid_irdy", in_ready, 1);
    repeat (10) tick();
    send_rnd();
    drain();

    d_a = 8'hFF;
    d_b = 8'h01;
    d_c = 1'b1;
    d_v = 1'b1;
    tick();
    d_v = 1'b0;
    l1 = -1;
    l8 = -1;
    v1 = '0;
    v8 = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (r1_v && l1 < 0) begin
        l1 = i;
        v1 = {r1_c, r1_o};
      end
      if (r8_v && l8 < 0) begin
        l8 = i;
        v8 = {r8_c, r8_o};
      end
    end
    check("s1_lat", l1, 1);
    check("s1_res", v1, 9'h101);
    check("s8_lat", l8, 8);
    check("s8_res", v8, 9'h101);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
